// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding, register map, STATUS bit positions and baud divisor helper.
package uart_tx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 8;
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; a push is accepted only when not full at that edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two in 2..256");
    end
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with TX FIFO and combinational status reads.
// Define UART_TX_BAUD_REG_EN to add a run-time BAUDDIV register at offset 0x8.
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);
    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam logic [15:0] DIV16 = 16'(DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("uart_tx_mmio: baud divisor out of range 2..65535");
    end
    state_e state_q;
    logic [15:0] bcnt_q, bdiv;
    logic [2:0] bit_q;
    logic [7:0] shift_q, fifo_rdata;
    logic txd_q, ovf_q;
    logic [CW-1:0] cnt;
    logic full, empty, busy, pop, bit_end;
    logic wr, push_req, ovf_clr;
    logic [1:0] sel;
    logic [31:0] status, baud_rd;
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8], byte_enable[3:1]};
    assign sel      = addr[3:2];
    assign wr       = !cs_n && we;
    assign push_req = wr && sel == TXDATA_OFS[3:2] && byte_enable[0];
    assign ovf_clr  = wr && sel == STATUS_OFS[3:2] && byte_enable[0] && wdata[ST_OVF];
    assign busy     = state_q != IDLE;
    assign pop      = state_q == IDLE && !empty;
    assign bit_end  = bcnt_q == bdiv - 16'd1;
    assign txd      = txd_q;
    assign irq      = empty && state_q == IDLE;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdata_i (wdata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (cnt)
    );
`ifdef UART_TX_BAUD_REG_EN
    logic [15:0] baud_q, fdiv_q;
    logic wr_baud;
    assign wr_baud = wr && sel == BAUDDIV_OFS[3:2];
    // The divisor is latched at the pop so a frame in flight keeps its bit time.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_q <= DIV16;
            fdiv_q <= DIV16;
        end else begin
            if (wr_baud && byte_enable[0]) baud_q[7:0] <= wdata[7:0];
            if (wr_baud && byte_enable[1]) baud_q[15:8] <= wdata[15:8];
            if (pop) fdiv_q <= (baud_q < 16'd2) ? 16'd2 : baud_q;
        end
    end
    assign bdiv    = fdiv_q;
    assign baud_rd = {16'd0, baud_q};
`else
    assign bdiv    = DIV16;
    assign baud_rd = 32'd0;
`endif
    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= (push_req && full) || (ovf_q && !ovf_clr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (!empty) begin
                    shift_q <= fifo_rdata;
                    bcnt_q  <= '0;
                    txd_q   <= 1'b0;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    bcnt_q  <= '0;
                    bit_q   <= '0;
                    txd_q   <= shift_q[0];
                    state_q <= DATA;
                end else bcnt_q <= bcnt_q + 16'd1;
                DATA: if (bit_end) begin
                    bcnt_q  <= '0;
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 3'd1;
                    txd_q   <= (bit_q == 3'd7) ? 1'b1 : shift_q[1];
                    if (bit_q == 3'd7) state_q <= STOP;
                end else bcnt_q <= bcnt_q + 16'd1;
                STOP: if (bit_end) begin
                    bcnt_q  <= '0;
                    state_q <= IDLE;
                end else bcnt_q <= bcnt_q + 16'd1;
            endcase
        end
    end
    always_comb begin
        status = 32'(cnt) << ST_CNT;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf_q;
    end
    assign rdata = cs_n ? 32'd0 :
                   sel == STATUS_OFS[3:2]  ? status :
                   sel == BAUDDIV_OFS[3:2] ? baud_rd : 32'd0;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench, DIV=10 and a 4-entry FIFO.
module tb_uart_tx_mmio;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs_n = 1'b1;
    logic we = 1'b0;
    logic [3:0] addr = '0;
    logic [3:0] byte_enable = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic txd, irq;
    int total = 0;
    int bad = 0;
    uart_tx_mmio #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .we          (we),
        .addr        (addr),
        .byte_enable (byte_enable),
        .wdata       (wdata),
        .rdata       (rdata),
        .txd         (txd),
        .irq         (irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        cs_n = 1'b0;
        we = 1'b1;
        addr = a;
        wdata = d;
        byte_enable = be;
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        we = 1'b0;
        byte_enable = '0;
    endtask
    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        cs_n = 1'b0;
        we = 1'b0;
        addr = a;
        #1;
        d = rdata;
        cs_n = 1'b1;
    endtask
    // Starts just after the pop edge; each of the 10 bit slots must hold its level for div cycles.
    task automatic frame(input string tag, input logic [7:0] b, input int div);
        for (int k = 0; k < 10; k++) begin
            logic e;
            int good;
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            good = 0;
            repeat (div) begin
                if (txd === e) good++;
                tick(1);
            end
            check($sformatf("%s_bit%0d", tag, k), good, div);
        end
    endtask
    initial begin
        logic [31:0] r;
        logic [7:0] bs [6];
        int lows;
        bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC5, 8'h66};
        tick(3);
        reset = 1'b0;
        check("rst_txd", txd, 1);
        check("rst_irq", irq, 1);
        rd(4'h4, r); check("rst_status", r, 32'h4);
        rd(4'h0, r); check("rd_txdata", r, 0);
        rd(4'hC, r); check("rd_resv", r, 0);
        addr = 4'h4; #1; check("rd_unsel", rdata, 0);
        // single frame 0x55
        wr(4'h0, 32'h55, 4'b0001);
        check("t1_txd_n", txd, 1);
        rd(4'h4, r); check("t1_status_n", r, 32'h100);
        tick(1);
        frame("t1", 8'h55, 10);
        check("t1_irq", irq, 1);
        // back-to-back frames
        wr(4'h0, 32'hA3, 4'b0001);
        wr(4'h0, 32'h0F, 4'b0001);
        rd(4'h4, r); check("t2_status_f1", r, 32'h101);
        frame("t2a", 8'hA3, 10);
        check("t2_idle_txd", txd, 1);
        rd(4'h4, r); check("t2_idle_status", r, 32'h100);
        tick(1);
        frame("t2b", 8'h0F, 10);
        check("t2_irq", irq, 1);
        // overflow: six stores, five accepted
        for (int i = 0; i < 6; i++) wr(4'h0, {24'd0, bs[i]}, 4'b0001);
        rd(4'h4, r); check("t3_full_ovf", r, 32'h40B);
        wr(4'h4, 32'h8, 4'b0001);
        rd(4'h4, r); check("t3_ovf_clr", r, 32'h403);
        tick(399);
        frame("t3e", 8'hC5, 10);
        check("t3_irq", irq, 1);
        rd(4'h4, r); check("t3_status_end", r, 32'h4);
        // wrong byte lane
        wr(4'h0, 32'h7700, 4'b0010);
        rd(4'h4, r); check("t4_status", r, 32'h4);
        tick(3);
        check("t4_txd", txd, 1);
        // reset mid-frame
        wr(4'h0, 32'hF0, 4'b0001);
        wr(4'h0, 32'h12, 4'b0001);
        wr(4'h0, 32'h34, 4'b0001);
        rd(4'h4, r); check("t5_status_q", r, 32'h201);
        tick(43);
        check("t5_bit3", txd, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_txd", txd, 1);
        check("t5_irq", irq, 1);
        rd(4'h4, r); check("t5_status", r, 32'h4);
        lows = 0;
        repeat (300) begin
            if (txd !== 1'b1) lows++;
            tick(1);
        end
        check("t5_quiet", lows, 0);
`ifdef UART_TX_BAUD_REG_EN
        rd(4'h8, r); check("t6_baud_rst", r, 10);
        wr(4'h0, 32'hB1, 4'b0001);
        wr(4'h0, 32'h4E, 4'b0001);
        tick(19);
        wr(4'h8, 32'h4, 4'b0011);
        rd(4'h8, r); check("t6_baud_rd4", r, 4);
        tick(79);
        rd(4'h4, r); check("t6_f1_stop", r, 32'h101);
        tick(1);
        rd(4'h4, r); check("t6_f1_done", r, 32'h100);
        tick(1);
        frame("t6b", 8'h4E, 4);
        check("t6_irq", irq, 1);
        wr(4'h8, 32'h1, 4'b0011);
        rd(4'h8, r); check("t6_baud_rd1", r, 1);
        wr(4'h0, 32'h96, 4'b0001);
        tick(1);
        frame("t6c", 8'h96, 2);
        check("t6c_irq", irq, 1);
`else
        wr(4'h8, 32'h1234, 4'b1111);
        rd(4'h8, r); check("t6_resv8", r, 0);
        rd(4'h4, r); check("t6_status", r, 32'h4);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter; a bus responder on the RV32I core's data port, selected by the system address decoder through cs_uart_n.
- The CPU stores bytes into a TX FIFO. An 8N1 serialiser drains the FIFO onto UART_TXD.
- Reads return status combinationally, matching the core's single-cycle asynchronous-read data path.

Parameters:
- CLOCK_FREQ, 125_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, range 2..256.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cs_n  input  1  active-low chip select from the address decoder.
- we  input  1  write strobe (the core's MemWrite); a write occurs when cs_n=0 and we=1.
- addr  input  4  byte offset within the block, DataAdr[3:0]; bits [1:0] are ignored.
- byte_enable  input  4  store byte lanes.
- wdata  input  32  store data.
- rdata  output  32  combinational read data; reads 0 when cs_n=1.
- txd  output  1  serial output; idles high.
- irq  output  1  high while the FIFO is empty and the serialiser is idle.

Behaviour:
- Divisor: DIV = (CLOCK_FREQ + BAUD_RATE/2) / BAUD_RATE, computed at elaboration. Elaboration fails if DIV < 2.
- Register map (word offsets):
  - 0x0 TXDATA (W): wdata[7:0] is pushed when byte_enable[0]=1. Reads return 0.
  - 0x4 STATUS (R): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] FIFO count. Writing wdata[3]=1 with byte_enable[0]=1 clears overflow.
  - 0x8 and 0xC: reserved; reads return 0, writes are ignored.
- Push: accepted iff the FIFO is not full at that edge. A pop in the same cycle does not make room.
- Write while full: data is dropped and overflow is set the following cycle.
- FIFO: pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1, zero-extended into bits [15:8].
- FSM states: IDLE, START, DATA, STOP. A baud counter bcnt runs 0..DIV-1 in every non-IDLE state.
  - IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, set bcnt=0, go to START. A push in the same cycle to an empty FIFO is not visible until the next cycle.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles per bit, LSB first. Shift right at each bit end. After bit 7, go to STOP.
  - STOP: txd=1 for DIV cycles, then go to IDLE.
- Back-to-back bytes: with the FIFO non-empty, exactly one IDLE cycle separates frames.
- busy: high in START, DATA and STOP.
- Latency: a write at edge N makes the FIFO non-empty after N. The pop occurs at edge N+1, and txd falls after edge N+1, i.e. 2 cycles after the store.
- Reset (any state, including mid-frame): state=IDLE, txd=1 after the edge, FIFO flushed, count=0, overflow=0, bcnt=0, irq=1. A frame cut by reset is not resumed.
- rdata: depends only on cs_n, addr and current registers; no read side effects.

Optional Feature:
- Macro: UART_TX_BAUD_REG_EN.
- Defined: a 16-bit BAUDDIV register at offset 0x8 (R/W, byte enables honoured). Its reset value is DIV and it replaces DIV in the FSM. Values below 2 are clamped to 2. A write takes effect at the next frame start; the current frame keeps its old divisor.
- Undefined: offset 0x8 is reserved and DIV is a constant.

Decomposition:
- Package uart_tx_pkg holds:
  - the FSM state encoding (2-bit, IDLE=0, START=1, DATA=2, STOP=3);
  - the register offset localparams TXDATA_OFS, STATUS_OFS, BAUDDIV_OFS;
  - the STATUS bit indices;
  - the DIV computation function.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/count, synchronous active-high reset. It is reusable by a later UART receiver.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, DIV=10, FIFO_DEPTH=4):
- Store 0x55 to 0x0, byte_enable=0001 -> txd low 2 cycles later. Then 10-cycle bits 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); 100 cycles total; then irq=1.
- Store 0xA3 then 0x0F back-to-back -> two frames separated by exactly one IDLE cycle. STATUS count reads 1 during frame 1 after the first pop.
- 6 stores within 6 cycles, while idle -> 5 frames sent. STATUS reads full=1 and overflow=1 while full. After writing 0x8 to STATUS, overflow=0.
- Store with byte_enable=0010 to 0x0 -> no push, count stays 0, txd stays 1.
- Assert reset for 1 cycle at data bit 3 of a frame, with 2 bytes queued -> txd=1 next cycle, STATUS reads 0x00000004, no further frames.
- With UART_TX_BAUD_REG_EN: write BAUDDIV=4 mid-frame -> current frame keeps 10-cycle bits, next frame uses 4-cycle bits. Write 1 -> readback 1, bit time 2 cycles.
